// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl
//   Multi-cycle multiply/divide sequencer that owns the HI/LO register pair.
//   A start pulse latches the operands. The result is computed into pending
//   registers at that edge. A 4-bit counter then runs down the fixed latency.
//   The pending result is committed to HI/LO on the last counted edge.
//   mthi/mtlo write HI/LO directly in a single cycle.
//
// Ports
//   i_clk     system clock, rising edge
//   i_reset   synchronous active-high reset, highest priority
//   i_start   qualifies i_md_op this cycle
//   i_md_op   000 none, 001 mult, 010 multu, 011 div, 100 divu,
//             101 mthi, 110 mtlo, 111 reserved
//   i_flush   cancels acceptance of a start in the same cycle
//   i_a       rs operand (forwarded)
//   i_b       rt operand (forwarded)
//   o_busy    multiply/divide in flight
//   o_hi      HI register
//   o_lo      LO register
module hilo_md_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [2:0]  i_md_op,
   input  logic        i_flush,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_busy,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;
   localparam logic [2:0] OP_RSVD  = 3'b111;

   localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

   logic        r_busy;
   logic [3:0]  r_cnt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_pend_hi;
   logic [31:0] r_pend_lo;
   logic        r_pend_wr;   // 0 for a divide by zero: commit leaves HI/LO alone

   logic        w_accept;
   logic        w_is_div;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_b_div;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;
   logic        w_res_wr;

   assign w_accept = i_start & ~i_flush & ~r_busy &
                     (i_md_op != OP_NONE) & (i_md_op != OP_RSVD);
   assign w_is_div = (i_md_op == OP_DIV) | (i_md_op == OP_DIVU);

   assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   // Signed divide goes through unsigned magnitudes so that the
   // 0x80000000 / -1 case yields quotient 0x80000000 and remainder 0.
   // It never reaches a signed-overflow divide.
   assign w_a_neg = (i_md_op == OP_DIV) & i_a[31];
   assign w_b_neg = (i_md_op == OP_DIV) & i_b[31];
   assign w_a_mag = w_a_neg ? (~i_a + 32'd1) : i_a;
   assign w_b_mag = w_b_neg ? (~i_b + 32'd1) : i_b;
   // A zero divisor is replaced by 1 to keep the divider defined.
   // The result is discarded anyway through w_res_wr.
   assign w_b_div = (i_b == 32'd0) ? 32'd1 : w_b_mag;
   assign w_q_mag = w_a_mag / w_b_div;
   assign w_r_mag = w_a_mag % w_b_div;
   assign w_quot  = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
   assign w_rem   = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

   always_comb begin
      w_res_hi = 32'd0;
      w_res_lo = 32'd0;
      w_res_wr = 1'b1;
      case (i_md_op)
         OP_MULT: begin
            w_res_hi = w_prod_s[63:32];
            w_res_lo = w_prod_s[31:0];
         end
         OP_MULTU: begin
            w_res_hi = w_prod_u[63:32];
            w_res_lo = w_prod_u[31:0];
         end
         OP_DIV, OP_DIVU: begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
            w_res_wr = (i_b != 32'd0);
         end
         default: begin
            w_res_wr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_busy    <= 1'b0;
         r_cnt     <= 4'd0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_pend_wr <= 1'b0;
      end else if (w_accept) begin
         case (i_md_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
               r_pend_hi <= w_res_hi;
               r_pend_lo <= w_res_lo;
               r_pend_wr <= w_res_wr;
               r_busy    <= 1'b1;
               r_cnt     <= w_is_div ? C_DIV_CNT : C_MULT_CNT;
            end
            OP_MTHI: r_hi <= i_a;
            OP_MTLO: r_lo <= i_a;
            default: ;
         endcase
      end else if (r_busy) begin
         if (r_cnt == 4'd1) begin
            r_busy <= 1'b0;
            r_cnt  <= 4'd0;
            if (r_pend_wr) begin
               r_hi <= r_pend_hi;
               r_lo <= r_pend_lo;
            end
         end else begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   assign o_busy = r_busy;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair.
- Sits in the E stage. Latches operands on a start pulse and counts down a fixed latency. Commits the result to HI/LO at the end of the count.
- Drives `busy` so hazard logic can stall any HI/LO-touching instruction in D.
- HI/LO outputs feed the E/M/W write-data selection for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  qualifies md_op this cycle.
- md_op  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (no-op).
- flush  in  1  exception/interrupt cancel; blocks acceptance of the current start.
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- busy  out  1  operation in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset:
  - On a rising edge with reset=1: busy=0, HI=0, LO=0, internal counter=0, pending result regs=0.
  - Reset has priority over all other inputs.
  - Reset mid-operation discards the in-flight result; HI/LO go to 0, not to the pending value.
- Acceptance:
  - An op is accepted at an edge iff start=1, flush=0, busy=0, and md_op is one of 001..110.
  - Otherwise start has no effect. Start while busy is ignored with no queueing; the stall logic is required to prevent it.
- mult/multu/div/divu:
  - At the accept edge: compute the result from A and B and store it in the pending regs.
  - Set busy=1 and counter=MULT_CYCLES or DIV_CYCLES.
  - At each later edge with counter>1: counter decrements.
  - At the edge where counter==1: HI/LO <= pending, busy<=0, counter<=0.
  - busy is therefore high for exactly N cycles after the start cycle. The new HI/LO is visible in the cycle busy first reads 0.
- mthi/mtlo:
  - At the accept edge: HI<=A (mthi) or LO<=A (mtlo).
  - busy stays 0; single-cycle operation.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product of A and B.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0.
- Divide by zero (B==0, div or divu):
  - Still sequences busy for DIV_CYCLES.
  - HI/LO keep their prior values at commit; no update.
- flush:
  - Affects only the acceptance of a new start; an in-flight op runs to completion.
  - flush=1 together with start: nothing changes.
- Counter width: 4 bits. No wrap-around is possible with legal parameters.
- HI/LO change only at a commit edge, at an accepted mthi/mtlo edge, or at reset. They are stable at all other times.

Test Plan:
- Reset, then start with mult, A=0xFFFFFFFE (-2), B=3 → busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy=0.
- Start with divu, A=100, B=7 → busy high 10 cycles; then LO=14, HI=2. Follow with div, A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Start with mthi A=0x12345678, next cycle mtlo A=0x9ABCDEF0 → HI and LO each update one edge after their start; busy never asserts.
- During a div in flight (cycle 3): start with mult and an mtlo → both ignored; div result commits at cycle 10; HI/LO not touched by the mtlo.
- Start with div, B=0, HI=LO=0x55 beforehand → busy for 10 cycles; HI/LO remain 0x55. Start with mult and flush=1 → busy stays 0; HI/LO unchanged.
- Start with multu A=B=0xFFFFFFFF, reset asserted at cycle 2 → at that edge busy=0, HI=LO=0; no later commit occurs.
